// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: shared types for the AES slave sequencing FSM.
//   state_t : 4-bit encoded controller state.
package aes_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    READ_KEY   = 4'd1,
    KEY_EXP    = 4'd2,
    READ_DATA  = 4'd3,
    ADD_ROUND  = 4'd4,
    SUB_BYTES  = 4'd5,
    SHIFT_ROWS = 4'd6,
    MIX_COL    = 4'd7,
    WRITE      = 4'd8
  } state_t;

endpackage

// File: rtl/aes_controller.sv
// aes_controller: top-level sequencing FSM of the AHB AES encryption slave.
// Decodes bus requests into key load / key expansion / plaintext load /
// round sequence / result readback and raises one datapath-stage enable per
// state. It holds no datapath state; round progress comes back through the
// *_finished inputs.
//   clk, n_rst           : clock, synchronous active-low reset
//   addrMatch            : 1 = key register addressed, 0 = data register
//   HSELx, mWrite, mRead : AHB slave select and master direction
//   dataReady            : bus word captured / result delivered
//   finished             : datapath is in the final round (level)
//   *_finished           : per-stage completion
//   HREADYOUT            : 1 only in IDLE (bus stalled otherwise)
//   *_enable             : one-hot stage enables (Moore)
module aes_controller
  import aes_ctrl_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic addrMatch,
  input  logic HSELx,
  input  logic mWrite,
  input  logic mRead,
  input  logic dataReady,
  input  logic finished,
  input  logic keyexp_finished,
  input  logic sbytes_finished,
  input  logic srows_finished,
  input  logic mcol_finished,
  input  logic around_finished,
  output logic HREADYOUT,
  output logic readk_enable,
  output logic read_enable,
  output logic write_enable,
  output logic keyexp_enable,
  output logic sbytes_enable,
  output logic srows_enable,
  output logic mcol_enable,
  output logic around_enable
);

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        // Write beats read when both are requested.
        if (HSELx && mWrite)     state_d = addrMatch ? READ_KEY : READ_DATA;
        else if (HSELx && mRead) state_d = WRITE;
      end
      READ_KEY:   if (dataReady)       state_d = KEY_EXP;
      KEY_EXP:    if (keyexp_finished) state_d = IDLE;
      READ_DATA:  if (dataReady)       state_d = ADD_ROUND;
      // After the final round's AddRoundKey the ciphertext sits in the datapath.
      ADD_ROUND:  if (around_finished) state_d = finished ? IDLE : SUB_BYTES;
      SUB_BYTES:  if (sbytes_finished) state_d = SHIFT_ROWS;
      // Final round skips MixColumns.
      SHIFT_ROWS: if (srows_finished)  state_d = finished ? ADD_ROUND : MIX_COL;
      MIX_COL:    if (mcol_finished)   state_d = ADD_ROUND;
      WRITE:      if (dataReady)       state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  assign HREADYOUT     = (state_q == IDLE);
  assign readk_enable  = (state_q == READ_KEY);
  assign read_enable   = (state_q == READ_DATA);
  assign write_enable  = (state_q == WRITE);
  assign keyexp_enable = (state_q == KEY_EXP);
  assign sbytes_enable = (state_q == SUB_BYTES);
  assign srows_enable  = (state_q == SHIFT_ROWS);
  assign mcol_enable   = (state_q == MIX_COL);
  assign around_enable = (state_q == ADD_ROUND);

endmodule

// File: tb/tb_aes_controller.sv
// tb_aes_controller: directed-vector bench for aes_controller.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_aes_controller;

  logic clk = 1'b0;
  logic n_rst;
  logic addrMatch, HSELx, mWrite, mRead, dataReady, finished;
  logic keyexp_finished, sbytes_finished, srows_finished, mcol_finished, around_finished;
  logic HREADYOUT, readk_enable, read_enable, write_enable;
  logic keyexp_enable, sbytes_enable, srows_enable, mcol_enable, around_enable;

  always #5 clk = ~clk;

  aes_controller dut (
    .clk(clk), .n_rst(n_rst), .addrMatch(addrMatch), .HSELx(HSELx),
    .mWrite(mWrite), .mRead(mRead), .dataReady(dataReady), .finished(finished),
    .keyexp_finished(keyexp_finished), .sbytes_finished(sbytes_finished),
    .srows_finished(srows_finished), .mcol_finished(mcol_finished),
    .around_finished(around_finished), .HREADYOUT(HREADYOUT),
    .readk_enable(readk_enable), .read_enable(read_enable),
    .write_enable(write_enable), .keyexp_enable(keyexp_enable),
    .sbytes_enable(sbytes_enable), .srows_enable(srows_enable),
    .mcol_enable(mcol_enable), .around_enable(around_enable)
  );

  // {HREADYOUT, readk, read, write, keyexp, sbytes, srows, mcol, around}
  localparam logic [8:0] O_IDLE = 9'b1_0000_0000;
  localparam logic [8:0] O_RK   = 9'b0_1000_0000;
  localparam logic [8:0] O_RD   = 9'b0_0100_0000;
  localparam logic [8:0] O_WR   = 9'b0_0010_0000;
  localparam logic [8:0] O_KE   = 9'b0_0001_0000;
  localparam logic [8:0] O_SB   = 9'b0_0000_1000;
  localparam logic [8:0] O_SR   = 9'b0_0000_0100;
  localparam logic [8:0] O_MC   = 9'b0_0000_0010;
  localparam logic [8:0] O_AR   = 9'b0_0000_0001;

  logic [8:0] outs;
  assign outs = {HREADYOUT, readk_enable, read_enable, write_enable, keyexp_enable,
                 sbytes_enable, srows_enable, mcol_enable, around_enable};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr();
    addrMatch = 0; HSELx = 0; mWrite = 0; mRead = 0; dataReady = 0; finished = 0;
    keyexp_finished = 0; sbytes_finished = 0; srows_finished = 0;
    mcol_finished = 0; around_finished = 0;
  endtask

  // Enable counters for the full encryption run.
  logic cnt_en = 0;
  int c_ar = 0, c_sb = 0, c_sr = 0, c_mc = 0, c_mc_last = 0;
  always @(negedge clk) if (cnt_en) begin
    c_ar <= c_ar + int'(around_enable);
    c_sb <= c_sb + int'(sbytes_enable);
    c_sr <= c_sr + int'(srows_enable);
    c_mc <= c_mc + int'(mcol_enable);
    c_mc_last <= c_mc_last + int'(mcol_enable && finished);
  end

  initial begin
    clr();
    n_rst = 0;
    step(); step();
    chk("reset_state", 32'(outs), 32'(O_IDLE));
    n_rst = 1;

    // Drive into SUB_BYTES, then probe stray input and mid-run reset.
    HSELx = 1; mWrite = 1; mRead = 1; addrMatch = 0;
    step(); clr();
    chk("prio_write_over_read", 32'(outs), 32'(O_RD));
    dataReady = 1; step(); clr();
    chk("rd_to_ar", 32'(outs), 32'(O_AR));
    around_finished = 1; step(); clr();
    chk("ar_to_sb", 32'(outs), 32'(O_SB));
    mcol_finished = 1; step(); clr();
    chk("stray_mcol_hold", 32'(outs), 32'(O_SB));
    step();
    chk("sb_hold_no_done", 32'(outs), 32'(O_SB));
    n_rst = 0; step();
    chk("reset_mid_run_1", 32'(outs), 32'(O_IDLE));
    step(); n_rst = 1;
    chk("reset_mid_run_2", 32'(outs), 32'(O_IDLE));
    step();
    chk("no_resume_after_reset", 32'(outs), 32'(O_IDLE));

    // Key load.
    HSELx = 1; mWrite = 1; addrMatch = 1; step(); clr();
    chk("key_readk", 32'(outs), 32'(O_RK));
    step();
    chk("key_hold", 32'(outs), 32'(O_RK));
    dataReady = 1; step(); clr();
    chk("key_exp", 32'(outs), 32'(O_KE));
    keyexp_finished = 1; step(); clr();
    chk("key_done_idle", 32'(outs), 32'(O_IDLE));

    // Key load with done inputs held high: back in IDLE 2 cycles after leaving it.
    dataReady = 1; keyexp_finished = 1;
    HSELx = 1; mWrite = 1; addrMatch = 1; step();
    HSELx = 0; mWrite = 0;
    chk("fast_key_rk", 32'(outs), 32'(O_RK));
    step();
    chk("fast_key_ke", 32'(outs), 32'(O_KE));
    step(); clr();
    chk("fast_key_idle", 32'(outs), 32'(O_IDLE));

    // Full 10-round encryption.
    cnt_en = 1;
    HSELx = 1; mWrite = 1; addrMatch = 0; step(); clr();
    chk("enc_read_data", 32'(outs), 32'(O_RD));
    dataReady = 1; step(); clr();
    for (int r = 1; r <= 10; r++) begin
      chk($sformatf("enc_ar_r%0d", r), 32'(outs), 32'(O_AR));
      around_finished = 1; step(); around_finished = 0;
      chk($sformatf("enc_sb_r%0d", r), 32'(outs), 32'(O_SB));
      if (r == 10) finished = 1;
      sbytes_finished = 1; step(); sbytes_finished = 0;
      chk($sformatf("enc_sr_r%0d", r), 32'(outs), 32'(O_SR));
      srows_finished = 1; step(); srows_finished = 0;
      if (r < 10) begin
        chk($sformatf("enc_mc_r%0d", r), 32'(outs), 32'(O_MC));
        mcol_finished = 1; step(); mcol_finished = 0;
      end
    end
    chk("enc_final_ar", 32'(outs), 32'(O_AR));
    around_finished = 1; step(); around_finished = 0;
    chk("enc_done_idle", 32'(outs), 32'(O_IDLE));
    finished = 0; cnt_en = 0;
    step();
    chk("cnt_around", 32'(c_ar), 32'd11);
    chk("cnt_sbytes", 32'(c_sb), 32'd10);
    chk("cnt_srows", 32'(c_sr), 32'd10);
    chk("cnt_mcol", 32'(c_mc), 32'd9);
    chk("no_mcol_last_round", 32'(c_mc_last), 32'd0);

    // Readback.
    HSELx = 1; mRead = 1; step(); clr();
    chk("rb_write", 32'(outs), 32'(O_WR));
    step();
    chk("rb_hold", 32'(outs), 32'(O_WR));
    dataReady = 1; step(); clr();
    chk("rb_idle", 32'(outs), 32'(O_IDLE));

    // Idle hold without select.
    mWrite = 1; addrMatch = 1; dataReady = 1; step();
    chk("idle_hold_nosel", 32'(outs), 32'(O_IDLE));
    mWrite = 0; mRead = 1; step(); clr();
    chk("idle_hold_nosel_rd", 32'(outs), 32'(O_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_controller.md
# aes_controller

Top-level sequencing FSM of the AHB-attached AES encryption slave. It decodes AHB slave requests into key load, key expansion, plaintext load, the AES round sequence and result readback. It drives one enable per datapath stage and the AHB HREADYOUT stall signal. It holds no datapath state; round counting and data registers live in the datapath, which reports completion through the `*_finished` inputs.

## Interface
- No parameters.
- clk  in  1  system clock, all state changes on rising edge
- n_rst  in  1  reset, synchronous, active-low
- addrMatch  in  1  current AHB address selects the key register (0 = data register)
- HSELx  in  1  AHB slave select
- mWrite  in  1  master write request
- mRead  in  1  master read request
- dataReady  in  1  bus-side data transfer complete (key/data word captured or result delivered)
- finished  in  1  datapath round counter is at the final round (level)
- keyexp_finished  in  1  key expansion done
- sbytes_finished, srows_finished, mcol_finished, around_finished  in  1 each  SubBytes / ShiftRows / MixColumns / AddRoundKey stage done
- HREADYOUT  out  1  1 = slave ready, 0 = stall bus
- readk_enable  out  1  capture key from bus
- read_enable  out  1  capture plaintext from bus
- write_enable  out  1  drive ciphertext to bus
- keyexp_enable, sbytes_enable, srows_enable, mcol_enable, around_enable  out  1 each  run the corresponding datapath stage

## Operation
- States: IDLE, READ_KEY, KEY_EXP, READ_DATA, ADD_ROUND, SUB_BYTES, SHIFT_ROWS, MIX_COL, WRITE.
- Moore outputs. Each enable is 1 only in its own state:
  - readk_enable in READ_KEY
  - read_enable in READ_DATA
  - write_enable in WRITE
  - keyexp_enable in KEY_EXP
  - sbytes_enable in SUB_BYTES
  - srows_enable in SHIFT_ROWS
  - mcol_enable in MIX_COL
  - around_enable in ADD_ROUND
- At most one enable is high at any time.
- HREADYOUT = 1 only in IDLE, 0 in every other state.
- IDLE transitions, checked in priority order:
  - HSELx & mWrite & addrMatch → READ_KEY
  - HSELx & mWrite & !addrMatch → READ_DATA
  - HSELx & mRead → WRITE
  - otherwise stay in IDLE.
  - mWrite wins over mRead if both are asserted.
- READ_KEY: dataReady → KEY_EXP.
- KEY_EXP: keyexp_finished → IDLE.
- READ_DATA: dataReady → ADD_ROUND (initial AddRoundKey).
- ADD_ROUND: on around_finished, finished=1 → IDLE (ciphertext valid in datapath); finished=0 → SUB_BYTES.
- SUB_BYTES: sbytes_finished → SHIFT_ROWS.
- SHIFT_ROWS: on srows_finished, finished=1 → ADD_ROUND (final round skips MixColumns); finished=0 → MIX_COL.
- MIX_COL: mcol_finished → ADD_ROUND.
- WRITE: dataReady → IDLE.
- Any state whose exit condition is not met holds its state.
- `*_finished` inputs for stages other than the current state are ignored.
- No key-valid tracking: a data write before any key load runs the sequence with whatever key the datapath holds.

## Timing
- n_rst=0 at a rising edge → state IDLE. Outputs then read HREADYOUT=1 and all enables 0.
- Reset applies from any state, mid-encryption included. No partial sequence resumes afterwards.
- All transitions take one clock after the condition is sampled high.
- An enable stays high during the cycle its finished/dataReady is sampled and drops in the next cycle.
- Minimum latencies with every done input already high:
  - key load to IDLE: 2 cycles after leaving IDLE
  - readback: 1 cycle
- A full 10-round encryption visits:
  - ADD_ROUND 11 times
  - SUB_BYTES and SHIFT_ROWS 10 times
  - MIX_COL 9 times
- Level-held done inputs may cause back-to-back transitions; there is no edge detection.

## Structure
- Package aes_ctrl_pkg holds the state enum typedef (state_t, 4-bit encoding).
- Single module with two blocks: a state register and combinational next-state/output logic. No sub-module.

## Test plan
- Reset: hold n_rst=0 two cycles from mid-SUB_BYTES → HREADYOUT=1, all enables 0, state IDLE.
- Key load: HSELx=1, mWrite=1, addrMatch=1.
  - Expect readk_enable=1 and HREADYOUT=0 next cycle.
  - dataReady=1 → keyexp_enable=1.
  - keyexp_finished=1 → IDLE with HREADYOUT=1.
- Full encryption: data write with addrMatch=0, dataReady, then pulse each stage's finished, with finished=1 only in round 10.
  - Expect enable counts: around 11, sbytes 10, srows 10, mcol 9.
  - Expect no mcol_enable in the last round.
  - Expect return to IDLE.
- Readback: HSELx=1, mRead=1 → write_enable=1 and HREADYOUT=0; dataReady=1 → IDLE next cycle.
- Priority and stall: mWrite=1 and mRead=1 together with addrMatch=0 → READ_DATA, not WRITE.
  - Stray mcol_finished=1 while in SUB_BYTES → no state change.
- Idle hold: HSELx=0 with mWrite=1 → remains IDLE, all enables 0.
